// File: rtl/timer_peripheral.sv
// rtl/timer_peripheral.sv - memory-mapped prescaled timer with compare match, reload/one-shot and level irq
// Optional feature macro: TIMER_CAPTURE_EN (capture_in input, CAPTURE register at 0x28, STATUS[2] CAP).
module timer_peripheral #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0000_1000,
    parameter int          COUNT_W   = 32,
    parameter int          PRESC_W   = 16
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire  [63:0] data,
    input  logic [63:0] address,
    input  logic        read,
    input  logic        write,
`ifdef TIMER_CAPTURE_EN
    input  logic        capture_in,
`endif
    output logic        irq
);
    localparam logic [5:0] OFF_CTRL    = 6'h00;
    localparam logic [5:0] OFF_COUNT   = 6'h08;
    localparam logic [5:0] OFF_COMPARE = 6'h10;
    localparam logic [5:0] OFF_STATUS  = 6'h18;
    localparam logic [5:0] OFF_PRESC   = 6'h20;
    localparam logic [5:0] OFF_CAPTURE = 6'h28;

    logic [3:0]         r_ctrl;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] r_compare;
    logic [PRESC_W-1:0] r_prescale;
    logic [PRESC_W-1:0] r_pcnt;
    logic               r_match;
    logic               r_ovf;
    logic               r_irq;

    logic               w_sel;
    logic               w_wr;
    logic [5:0]         w_off;
    logic               w_wr_ctrl;
    logic               w_wr_count;
    logic               w_wr_compare;
    logic               w_wr_status;
    logic               w_wr_presc;
    logic               w_tick;
    logic               w_hit;
    logic               w_set_match;
    logic               w_set_ovf;
    logic [COUNT_W-1:0] w_count_nxt;
    logic [63:0]        w_rdata;
    logic               w_cap_flag;
    logic [COUNT_W-1:0] w_capture;
    logic               w_unused_bits;

    assign w_sel        = (address[63:6] == BASE_ADDR[63:6]);
    assign w_off        = address[5:0];
    assign w_wr         = write && w_sel && !read;
    assign w_wr_ctrl    = w_wr && (w_off == OFF_CTRL);
    assign w_wr_count   = w_wr && (w_off == OFF_COUNT);
    assign w_wr_compare = w_wr && (w_off == OFF_COMPARE);
    assign w_wr_status  = w_wr && (w_off == OFF_STATUS);
    assign w_wr_presc   = w_wr && (w_off == OFF_PRESC);
    assign w_unused_bits = ^data[63:COUNT_W];

    assign w_tick      = r_ctrl[0] && (r_pcnt == r_prescale);
    assign w_hit       = (r_count == r_compare);
    assign w_set_match = w_tick && w_hit;
    assign w_set_ovf   = w_tick && !w_hit && (&r_count);

    // A non-matching all-ones count wraps to zero through the plain increment.
    always_comb begin
        w_count_nxt = r_count;
        if (w_tick) begin
            if (w_hit && r_ctrl[1]) begin
                w_count_nxt = '0;
            end else begin
                w_count_nxt = r_count + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ctrl     <= '0;
            r_count    <= '0;
            r_compare  <= '0;
            r_prescale <= '0;
            r_pcnt     <= '0;
            r_match    <= 1'b0;
            r_ovf      <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= data[3:0];
            end else if (w_set_match && r_ctrl[2]) begin
                r_ctrl[0] <= 1'b0;
            end
            r_count <= w_wr_count ? data[COUNT_W-1:0] : w_count_nxt;
            if (w_wr_compare) begin
                r_compare <= data[COUNT_W-1:0];
            end
            if (w_wr_presc) begin
                r_prescale <= data[PRESC_W-1:0];
            end
            if (w_wr_presc || !r_ctrl[0] || w_tick) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + PRESC_W'(1);
            end
            // Flag sets take priority over a same-cycle write-1-to-clear.
            r_match <= w_set_match || (r_match && !(w_wr_status && data[0]));
            r_ovf   <= w_set_ovf || (r_ovf && !(w_wr_status && data[1]));
            r_irq   <= r_ctrl[3] && (r_match || r_ovf || w_cap_flag);
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic [2:0]         r_cap_sync;
    logic [COUNT_W-1:0] r_capture;
    logic               r_cap;
    logic               w_cap_edge;

    assign w_cap_edge = r_cap_sync[1] && !r_cap_sync[2];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cap_sync <= '0;
            r_capture  <= '0;
            r_cap      <= 1'b0;
        end else begin
            r_cap_sync <= {r_cap_sync[1:0], capture_in};
            if (w_cap_edge) begin
                r_capture <= r_count;
            end
            r_cap <= w_cap_edge || (r_cap && !(w_wr_status && data[2]));
        end
    end

    assign w_cap_flag = r_cap;
    assign w_capture  = r_capture;
`else
    assign w_cap_flag = 1'b0;
    assign w_capture  = '0;
`endif

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_CTRL:    w_rdata = 64'(r_ctrl);
            OFF_COUNT:   w_rdata = 64'(r_count);
            OFF_COMPARE: w_rdata = 64'(r_compare);
            OFF_STATUS:  w_rdata = 64'({w_cap_flag, r_ovf, r_match});
            OFF_PRESC:   w_rdata = 64'(r_prescale);
            OFF_CAPTURE: w_rdata = 64'(w_capture);
            default:     w_rdata = '0;
        endcase
    end

    assign data = (read && w_sel) ? w_rdata : 64'bz;
    assign irq  = r_irq;
endmodule

// File: tb/tb_timer_peripheral.sv
// tb/tb_timer_peripheral.sv - randomized bench for timer_peripheral against a cycle-timeline model
module tb_timer_peripheral;
    localparam logic [63:0] BASE = 64'h0000_0000_0000_1000;

    logic        clock;
    logic        reset;
    logic [63:0] address;
    logic        read;
    logic        write;
    logic        drv_oe;
    logic [63:0] drv_data;
    logic        irq;
    wire  [63:0] data;

    assign data = drv_oe ? drv_data : 64'bz;

    timer_peripheral dut (
        .clock   (clock),
        .reset   (reset),
        .data    (data),
        .address (address),
        .read    (read),
        .write   (write),
        .irq     (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: the prescaler is tracked as the absolute edge index of the next tick.
    logic        m_en, m_auto, m_one, m_irqen, m_match, m_ovf, m_irq;
    logic [31:0] m_count, m_cmp;
    logic [15:0] m_presc;
    longint      edge_n = 0;
    longint      t_next = 0;

    function automatic logic [63:0] m_read(input logic [5:0] off);
        case (off)
            6'h00:   return {60'b0, m_irqen, m_one, m_auto, m_en};
            6'h08:   return {32'b0, m_count};
            6'h10:   return {32'b0, m_cmp};
            6'h18:   return {62'b0, m_ovf, m_match};
            6'h20:   return {48'b0, m_presc};
            default: return 64'b0;
        endcase
    endfunction

    task automatic model_step();
        longint      cur     = edge_n + 1;
        logic        sel     = (address[63:6] == BASE[63:6]);
        logic        wr      = write && sel && !read;
        logic [5:0]  off     = address[5:0];
        logic        tick    = m_en && (cur == t_next);
        logic        set_m   = 1'b0;
        logic        set_o   = 1'b0;
        logic [31:0] n_count = m_count;
        logic [3:0]  n_ctrl  = {m_irqen, m_one, m_auto, m_en};
        logic [15:0] n_presc = m_presc;
        logic        prs_wr  = wr && (off == 6'h20);
        logic        clr_m   = wr && (off == 6'h18) && drv_data[0];
        logic        clr_o   = wr && (off == 6'h18) && drv_data[1];
        edge_n <= cur;
        if (reset) begin
            {m_en, m_auto, m_one, m_irqen, m_match, m_ovf, m_irq} <= '0;
            m_count <= '0;
            m_cmp   <= '0;
            m_presc <= '0;
        end else begin
            if (tick) begin
                if (m_count == m_cmp) begin
                    set_m   = 1'b1;
                    n_count = m_auto ? 32'd0 : m_count + 32'd1;
                    if (m_one) n_ctrl[0] = 1'b0;
                end else if (m_count == 32'hFFFF_FFFF) begin
                    n_count = 32'd0;
                    set_o   = 1'b1;
                end else begin
                    n_count = m_count + 32'd1;
                end
            end
            if (wr && off == 6'h00) n_ctrl  = drv_data[3:0];
            if (wr && off == 6'h08) n_count = drv_data[31:0];
            if (wr && off == 6'h10) m_cmp   <= drv_data[31:0];
            if (prs_wr)             n_presc = drv_data[15:0];
            if (n_ctrl[0] && (!m_en || tick || prs_wr)) t_next <= cur + longint'(n_presc) + 1;
            {m_irqen, m_one, m_auto, m_en} <= n_ctrl;
            m_count <= n_count;
            m_presc <= n_presc;
            m_match <= set_m || (m_match && !clr_m);
            m_ovf   <= set_o || (m_ovf && !clr_o);
            m_irq   <= m_irqen && (m_match || m_ovf);
        end
    endtask

    always @(posedge clock) model_step();

    always @(negedge clock) begin
        if (chk_en) begin
            check("irq", {63'b0, irq}, {63'b0, m_irq});
            if (read && address[63:6] == BASE[63:6]) check("rdata", data, m_read(address[5:0]));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic wr(input logic [5:0] off, input logic [63:0] d);
        address  = BASE + {58'b0, off};
        write    = 1'b1;
        drv_oe   = 1'b1;
        drv_data = d;
        @(posedge clock);
        #1;
        write  = 1'b0;
        drv_oe = 1'b0;
    endtask

    task automatic rd_expect(input string name, input logic [5:0] off, input logic [63:0] exp);
        address = BASE + {58'b0, off};
        read    = 1'b1;
        #3;
        check(name, data, exp);
        @(posedge clock);
        #1;
        read = 1'b0;
    endtask

    function automatic logic [5:0] pick_off();
        case ($urandom_range(0, 7))
            0:       return 6'h00;
            1:       return 6'h08;
            2:       return 6'h10;
            3:       return 6'h18;
            4:       return 6'h20;
            5:       return 6'h28;
            6:       return 6'h30;
            default: return 6'h0C;
        endcase
    endfunction

    function automatic logic [63:0] rand_wdata(input logic [5:0] off);
        logic [63:0] d;
        d = {$urandom, $urandom};
        case (off)
            6'h00: d[0] = ($urandom_range(0, 3) != 0);
            6'h08: begin
                case ($urandom_range(0, 3))
                    0:       d[31:0] = 32'd0;
                    1:       d[31:0] = 32'($urandom_range(0, 15));
                    2:       d[31:0] = 32'hFFFF_FFFE;
                    default: d[31:0] = 32'hFFFF_FFFF;
                endcase
            end
            6'h10: d[31:0] = 32'($urandom_range(0, 15));
            6'h20: d[15:0] = 16'($urandom_range(0, 3));
            default: ;
        endcase
        return d;
    endfunction

    initial begin
        int         op;
        logic [5:0] off;
        reset    = 1'b1;
        read     = 1'b0;
        write    = 1'b0;
        drv_oe   = 1'b0;
        drv_data = '0;
        address  = '0;
        repeat (2) @(posedge clock);
        #1;
        reset  = 1'b0;
        chk_en = 1;

        for (int i = 0; i < 8; i++) rd_expect("reset_rd", 6'(i * 8), 64'd0);
        check("reset_irq", {63'b0, irq}, 64'd0);

        // Auto-reload with prescale: match lands 20 edges after the CTRL write.
        do_reset();
        wr(6'h20, 64'd3);
        wr(6'h10, 64'd4);
        wr(6'h00, 64'hB);
        idle(19);
        rd_expect("match_not_yet", 6'h18, 64'd0);
        check("irq_before", {63'b0, irq}, 64'd0);
        rd_expect("match_at_20", 6'h18, 64'd1);
        check("irq_after_match", {63'b0, irq}, 64'd1);
        rd_expect("count_reloaded", 6'h08, 64'd0);
        wr(6'h18, 64'd1);
        check("irq_still_high", {63'b0, irq}, 64'd1);
        idle(1);
        check("irq_cleared", {63'b0, irq}, 64'd0);
        wr(6'h00, 64'd0);

        // One-shot stops the timer after the match.
        do_reset();
        wr(6'h10, 64'd2);
        wr(6'h00, 64'h5);
        idle(6);
        rd_expect("oneshot_ctrl", 6'h00, 64'd4);
        rd_expect("oneshot_count", 6'h08, 64'd3);
        rd_expect("oneshot_status", 6'h18, 64'd1);

        // Overflow of an all-ones count.
        do_reset();
        wr(6'h08, 64'hDEAD_BEEF_FFFF_FFFF);
        wr(6'h10, 64'd5);
        wr(6'h00, 64'h1);
        idle(1);
        rd_expect("ovf_count", 6'h08, 64'd0);
        rd_expect("ovf_status", 6'h18, 64'd2);
        wr(6'h00, 64'd0);

        // COUNT write on a tick edge wins.
        do_reset();
        wr(6'h10, 64'd1000);
        wr(6'h00, 64'h1);
        idle(3);
        wr(6'h08, 64'd7);
        rd_expect("count_write_wins", 6'h08, 64'd7);

        // W1C on the match edge loses to the new set; read+write is ignored.
        do_reset();
        wr(6'h10, 64'd2);
        wr(6'h00, 64'h3);
        idle(2);
        wr(6'h18, 64'd1);
        rd_expect("set_beats_clear", 6'h18, 64'd1);
        wr(6'h00, 64'd0);
        address = BASE + 64'h18;
        read    = 1'b1;
        write   = 1'b1;
        @(posedge clock);
        #1;
        read  = 1'b0;
        write = 1'b0;
        rd_expect("rw_ignored", 6'h18, 64'd1);
        drv_oe   = 1'b1;
        drv_data = 64'd99;
        address  = BASE + 64'h50;
        write    = 1'b1;
        @(posedge clock);
        #1;
        write  = 1'b0;
        drv_oe = 1'b0;
        rd_expect("unsel_write_ignored", 6'h10, 64'd2);

        for (int i = 0; i < 4000; i++) begin
            op      = $urandom_range(0, 99);
            off     = pick_off();
            address = BASE + {58'b0, off};
            if (op == 0) begin
                reset = 1'b1;
            end else if (op < 40) begin
                read = 1'b0;
            end else if (op < 65) begin
                read = 1'b1;
            end else if (op < 90) begin
                write    = 1'b1;
                drv_oe   = 1'b1;
                drv_data = rand_wdata(off);
            end else if (op < 95) begin
                read  = 1'b1;
                write = 1'b1;
            end else begin
                address = BASE ^ (64'd1 << $urandom_range(6, 63));
                if (op[0]) begin
                    read = 1'b1;
                end else begin
                    write    = 1'b1;
                    drv_oe   = 1'b1;
                    drv_data = rand_wdata(off);
                end
            end
            @(posedge clock);
            #1;
            reset  = 1'b0;
            read   = 1'b0;
            write  = 1'b0;
            drv_oe = 1'b0;
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
